// File: rtl/mathv_pkg.sv
// Shared math-library definitions: deconvolution FSM states, width helpers
// and saturation limits for signed XW-bit samples.
package mathv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        MAC,
        DIV,
        STORE,
        FINISH
    } deconv_state_t;

    // Full-precision width of a lag-sum of n products of two xw-bit samples.
    function automatic int yw_of(input int n, input int xw);
        return 2 * xw + $clog2(n);
    endfunction

    // Two guard bits so y minus the running product sum never wraps.
    function automatic int aw_of(input int yw);
        return yw + 2;
    endfunction

    function automatic int xmax_of(input int xw);
        return (1 << (xw - 1)) - 1;
    endfunction

    function automatic int xmin_of(input int xw);
        return -(1 << (xw - 1));
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, fixed AW-cycle
// latency; done is high during the cycle whose edge retires the last bit.
module serial_divider #(
    parameter int AW = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] dividend,
    input  logic [AW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] quotient,
    output logic [AW-1:0] remainder
);

    localparam int CW = $clog2(AW + 1);

    logic [AW-1:0] rem_reg;
    logic [AW-1:0] quo_reg;
    logic [AW-1:0] dvs_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;

    logic [AW:0]   shifted;
    logic [AW:0]   trial;
    logic [AW-1:0] rem_next;
    logic          q_bit;

    // quo_reg starts as the dividend and fills with quotient bits from the LSB.
    always_comb begin
        shifted  = {rem_reg, quo_reg[AW-1]};
        trial    = shifted - {1'b0, dvs_reg};
        q_bit    = ~trial[AW];
        rem_next = q_bit ? trial[AW-1:0] : shifted[AW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            rem_reg  <= '0;
            quo_reg  <= dividend;
            dvs_reg  <= divisor;
            cnt_reg  <= CW'(AW);
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            rem_reg <= rem_next;
            quo_reg <= {quo_reg[AW-2:0], q_bit};
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = busy_reg && (cnt_reg == CW'(1));
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/deconvolution.sv
// Sequential deconvolution: recovers x from y = h * x (truncated to N samples)
// with one MAC per cycle followed by a serial divide by h[0] per sample.
module deconvolution
    import mathv_pkg::*;
#(
    parameter int N  = 8,
    parameter int XW = 8,
    parameter int YW = yw_of(N, XW),
    parameter int AW = aw_of(YW)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [N*YW-1:0] y_in,
    input  logic [N*XW-1:0] h_in,
    output logic            busy,
    output logic            done,
    output logic [N*XW-1:0] x_out,
    output logic            err_div0,
    output logic            err_inexact,
    output logic            err_ovf
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0]        POS_LIM = AW'(xmax_of(XW));
    localparam logic [AW-1:0]        NEG_LIM = AW'(-xmin_of(XW));
    localparam logic signed [XW-1:0] XMAX_V  = XW'(xmax_of(XW));
    localparam logic signed [XW-1:0] XMIN_V  = XW'(xmin_of(XW));

    deconv_state_t state_reg, state_next;

    logic signed [YW-1:0] y_arr [N];
    logic signed [XW-1:0] h_arr [N];
    logic signed [YW-1:0] y_reg [N];
    logic signed [XW-1:0] h_reg [N];
    logic signed [XW-1:0] x_reg [N];
    logic signed [AW-1:0] acc_reg;
    logic [NW-1:0]        n_reg;
    logic [NW-1:0]        k_reg;
    logic                 done_reg;
    logic                 err_div0_reg;
    logic                 err_inexact_reg;
    logic                 err_ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_io
            assign y_arr[gi]              = y_in[gi*YW +: YW];
            assign h_arr[gi]              = h_in[gi*XW +: XW];
            assign x_out[gi*XW +: XW]     = x_reg[gi];
        end
    endgenerate

    logic [NW-1:0]          n_inc;
    logic [NW-1:0]          x_idx;
    logic signed [AW-1:0]   y0_ext;
    logic signed [AW-1:0]   y_next_ext;
    logic signed [2*XW-1:0] mac_prod;
    logic signed [AW-1:0]   mac_acc;
    logic signed [AW-1:0]   load_acc;
    logic                   h0_zero;
    logic [XW-1:0]          h0_abs;

    assign n_inc      = n_reg + NW'(1);
    assign x_idx      = n_reg - k_reg;
    assign y0_ext     = {{(AW-YW){y_reg[0][YW-1]}}, y_reg[0]};
    assign y_next_ext = {{(AW-YW){y_reg[n_inc][YW-1]}}, y_reg[n_inc]};
    assign mac_prod   = h_reg[k_reg] * x_reg[x_idx];
    assign mac_acc    = acc_reg - {{(AW-2*XW){mac_prod[2*XW-1]}}, mac_prod};
    assign h0_zero    = (h_reg[0] == '0);
    assign h0_abs     = h_reg[0][XW-1] ? XW'(-h_reg[0]) : h_reg[0];

    // The divider loads on the edge that enters DIV, so it sees the final
    // accumulator value (y[0] from LATCH, or the last MAC result).
    assign load_acc = (state_reg == LATCH) ? y0_ext : mac_acc;

    logic          div_start;
    logic          div_busy;
    logic          div_done;
    logic [AW-1:0] div_dividend;
    logic [AW-1:0] div_divisor;
    logic [AW-1:0] div_quotient;
    logic [AW-1:0] div_remainder;

    assign div_dividend = load_acc[AW-1] ? AW'(-load_acc) : load_acc;
    assign div_divisor  = {{(AW-XW){1'b0}}, h0_abs};

    serial_divider #(.AW(AW)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // Re-apply the sign to the magnitude quotient and clamp into XW bits.
    logic                 q_neg;
    logic signed [XW-1:0] store_val;
    logic                 store_ovf;

    assign q_neg = acc_reg[AW-1] ^ h_reg[0][XW-1];

    always_comb begin
        store_ovf = 1'b0;
        store_val = q_neg ? XW'(-div_quotient[XW-1:0]) : div_quotient[XW-1:0];
        if (!q_neg && (div_quotient > POS_LIM)) begin
            store_val = XMAX_V;
            store_ovf = 1'b1;
        end else if (q_neg && (div_quotient > NEG_LIM)) begin
            store_val = XMIN_V;
            store_ovf = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_start  = 1'b0;
        case (state_reg)
            IDLE:   if (start) state_next = LATCH;
            LATCH: begin
                if (h0_zero) begin
                    state_next = FINISH;
                end else begin
                    state_next = DIV;
                    div_start  = ~div_busy;
                end
            end
            MAC: begin
                if (k_reg == n_reg) begin
                    state_next = DIV;
                    div_start  = ~div_busy;
                end
            end
            DIV:    if (div_done) state_next = STORE;
            STORE:  state_next = (n_reg == NW'(N - 1)) ? FINISH : MAC;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            for (int i = 0; i < N; i++) begin
                y_reg[i] <= '0;
                h_reg[i] <= '0;
                x_reg[i] <= '0;
            end
            acc_reg         <= '0;
            n_reg           <= '0;
            k_reg           <= '0;
            done_reg        <= 1'b0;
            err_div0_reg    <= 1'b0;
            err_inexact_reg <= 1'b0;
            err_ovf_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == FINISH);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            y_reg[i] <= y_arr[i];
                            h_reg[i] <= h_arr[i];
                            x_reg[i] <= '0;
                        end
                        n_reg           <= '0;
                        k_reg           <= NW'(1);
                        err_div0_reg    <= 1'b0;
                        err_inexact_reg <= 1'b0;
                        err_ovf_reg     <= 1'b0;
                    end
                end
                LATCH: begin
                    if (h0_zero) begin
                        err_div0_reg <= 1'b1;
                    end else begin
                        acc_reg <= y0_ext;
                    end
                end
                MAC: begin
                    acc_reg <= mac_acc;
                    k_reg   <= k_reg + NW'(1);
                end
                STORE: begin
                    x_reg[n_reg] <= store_val;
                    if (div_remainder != '0) err_inexact_reg <= 1'b1;
                    if (store_ovf) err_ovf_reg <= 1'b1;
                    if (n_reg != NW'(N - 1)) begin
                        n_reg   <= n_inc;
                        k_reg   <= NW'(1);
                        acc_reg <= y_next_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg == LATCH) || (state_reg == MAC) ||
                         (state_reg == DIV)   || (state_reg == STORE);
    assign done        = done_reg;
    assign err_div0    = err_div0_reg;
    assign err_inexact = err_inexact_reg;
    assign err_ovf     = err_ovf_reg;

endmodule

// File: tb/tb_deconvolution.sv
// Randomised and directed bench for deconvolution, checked every cycle
// against a plain-integer recursion model of the expected results.
module tb_deconvolution;
    import mathv_pkg::*;

    localparam int N  = 8;
    localparam int XW = 8;
    localparam int YW = yw_of(N, XW);
    localparam int AW = aw_of(YW);

    typedef int arr_t [N];

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N*YW-1:0] y_in;
    logic [N*XW-1:0] h_in;
    logic            busy;
    logic            done;
    logic [N*XW-1:0] x_out;
    logic            err_div0;
    logic            err_inexact;
    logic            err_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deconvolution #(.N(N), .XW(XW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .y_in        (y_in),
        .h_in        (h_in),
        .busy        (busy),
        .done        (done),
        .x_out       (x_out),
        .err_div0    (err_div0),
        .err_inexact (err_inexact),
        .err_ovf     (err_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: x[n] = (y[n] - sum h[k]x[n-k]) / h[0], truncating, clamped.
    function automatic void model(input arr_t y, input arr_t h, output arr_t x,
                                  output logic d0, output logic inex,
                                  output logic ovf, output int lat);
        longint acc;
        longint q;
        for (int i = 0; i < N; i++) x[i] = 0;
        d0 = 1'b0; inex = 1'b0; ovf = 1'b0;
        lat = 2;
        if (h[0] == 0) begin
            d0 = 1'b1;
        end else begin
            for (int n = 0; n < N; n++) begin
                acc = longint'(y[n]);
                for (int k = 1; k <= n; k++) acc -= longint'(h[k]) * longint'(x[n-k]);
                q = acc / longint'(h[0]);
                if ((acc % longint'(h[0])) != 0) inex = 1'b1;
                if (q > 127) begin q = 127; ovf = 1'b1; end
                else if (q < -128) begin q = -128; ovf = 1'b1; end
                x[n] = int'(q);
            end
            lat = 1 + N * (N - 1) / 2 + N * (AW + 1) + 1;
        end
    endfunction

    function automatic logic [N*YW-1:0] pack_y(input arr_t y);
        logic [N*YW-1:0] r;
        for (int i = 0; i < N; i++) r[i*YW +: YW] = YW'(y[i]);
        return r;
    endfunction

    function automatic logic [N*XW-1:0] pack_x(input arr_t v);
        logic [N*XW-1:0] r;
        for (int i = 0; i < N; i++) r[i*XW +: XW] = XW'(v[i]);
        return r;
    endfunction

    // Expectations handed from the driver to the monitor at start acceptance.
    logic [N*XW-1:0] pend_x, cur_x;
    logic            pend_d0, pend_inex, pend_ovf, cur_d0, cur_inex, cur_ovf;
    int              pend_lat, cur_lat;
    string           pend_name, cur_name;
    int              runs_done = 0;

    // Compare process: tracks edges since the accepted start and checks busy,
    // done timing and the final results against the model every cycle.
    initial begin : monitor
        bit run_active;
        int e;
        run_active = 1'b0;
        e = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                run_active = 1'b0;
            end else begin
                if (run_active) begin
                    e++;
                    if (e < cur_lat) begin
                        chk({cur_name, "_busy"}, 64'(busy), 64'(e <= cur_lat - 2));
                        chk({cur_name, "_done_early"}, 64'(done), 64'd0);
                    end else begin
                        chk({cur_name, "_latency"}, 64'(done), 64'd1);
                        chk({cur_name, "_busy_end"}, 64'(busy), 64'd0);
                        chk({cur_name, "_x"}, 64'(x_out), 64'(cur_x));
                        chk({cur_name, "_div0"}, 64'(err_div0), 64'(cur_d0));
                        chk({cur_name, "_inexact"}, 64'(err_inexact), 64'(cur_inex));
                        chk({cur_name, "_ovf"}, 64'(err_ovf), 64'(cur_ovf));
                        $display("run %s lat=%0d x=%h div0=%b inexact=%b ovf=%b",
                                 cur_name, cur_lat, x_out, err_div0, err_inexact, err_ovf);
                        run_active = 1'b0;
                        runs_done++;
                    end
                end else begin
                    chk("idle_done", 64'(done), 64'd0);
                    chk("idle_busy", 64'(busy), 64'd0);
                end
                if (!run_active && start === 1'b1) begin
                    cur_x = pend_x; cur_d0 = pend_d0; cur_inex = pend_inex;
                    cur_ovf = pend_ovf; cur_lat = pend_lat; cur_name = pend_name;
                    run_active = 1'b1;
                    e = -1;
                end
            end
        end
    end

    // Called just after a rising edge; start is high across exactly one edge.
    task automatic launch(input arr_t y, input arr_t h, input string name);
        arr_t x;
        logic d0, inex, ovf;
        int lat;
        model(y, h, x, d0, inex, ovf, lat);
        pend_x = pack_x(x); pend_d0 = d0; pend_inex = inex; pend_ovf = ovf;
        pend_lat = lat; pend_name = name;
        y_in = pack_y(y);
        h_in = pack_x(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int tgt;
        tgt = runs_done + 1;
        for (int i = 0; i < 1000 && runs_done < tgt; i++) @(posedge clk);
        #1;
        if (runs_done < tgt) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_x"}, 64'(x_out), 64'd0);
        chk({tag, "_errs"}, 64'({err_div0, err_inexact, err_ovf}), 64'd0);
    endtask

    initial begin : driver
        arr_t y, h, x, hz, xr;
        logic d0, inex, ovf;
        int lat;

        reset = 1'b1; start = 1'b0; y_in = '0; h_in = '0;
        pend_x = '0; pend_d0 = 0; pend_inex = 0; pend_ovf = 0; pend_lat = 2; pend_name = "none";
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Hand-computed values pinning the model.
        hz = '{0, 0, 0, 0, 0, 0, 0, 0};
        h = hz; h[0] = 1;
        y = '{3, -4, 5, 0, 127, -128, 1, 2};
        model(y, h, x, d0, inex, ovf, lat);
        chk("pin_identity_x", 64'(pack_x(x)), 64'h0201807f0005fc03);
        chk("pin_identity_lat", 64'(lat), 64'd206);
        h = hz; h[0] = 2; h[1] = 1;
        y = '{2, 5, 8, 11, 14, 17, 20, 23};
        model(y, h, x, d0, inex, ovf, lat);
        chk("pin_twotap_x", 64'(pack_x(x)), 64'h0807060504030201);
        h = hz; h[0] = -1; h[1] = 3;
        y = '{-5, 17, -6, 0, 0, 0, 0, 0};
        model(y, h, x, d0, inex, ovf, lat);
        chk("pin_signed_x", 64'(pack_x(x)), 64'h000000000000fe05);
        chk("pin_signed_flags", 64'({d0, inex, ovf}), 64'd0);
        h = hz; h[0] = 2; y = '{3, 0, 0, 0, 0, 0, 0, 0};
        model(y, h, x, d0, inex, ovf, lat);
        chk("pin_inexact", 64'({x[0], 2'(0), inex}), {32'd1, 3'b001});
        h = hz; h[0] = 1; y = '{200, 0, 0, 0, 0, 0, 0, 0};
        model(y, h, x, d0, inex, ovf, lat);
        chk("pin_ovf", 64'({x[0], ovf}), {32'd127, 1'b1});
        model(y, hz, x, d0, inex, ovf, lat);
        chk("pin_div0", 64'({lat, d0}), {32'd2, 1'b1});

        // Directed runs on the DUT.
        h = hz; h[0] = 1;
        launch('{3, -4, 5, 0, 127, -128, 1, 2}, h, "identity"); wait_done("identity");
        h = hz; h[0] = 2; h[1] = 1;
        launch('{2, 5, 8, 11, 14, 17, 20, 23}, h, "twotap"); wait_done("twotap");
        h = hz; h[0] = -1; h[1] = 3;
        launch('{-5, 17, -6, 0, 0, 0, 0, 0}, h, "signed"); wait_done("signed");
        launch('{9, 8, 7, 6, 5, 4, 3, 2}, hz, "div0"); wait_done("div0");
        h = hz; h[0] = 2;
        launch('{3, 0, 0, 0, 0, 0, 0, 0}, h, "inexact"); wait_done("inexact");
        h = hz; h[0] = 1;
        launch('{200, 0, 0, 0, 0, 0, 0, 0}, h, "ovf"); wait_done("ovf");
        h = hz; h[0] = -1;
        launch('{-200, 128, 0, 0, 0, 0, 0, 0}, h, "ovf_neg"); wait_done("ovf_neg");

        // A start pulse (with different data) in the middle of a run is ignored.
        h = hz; h[0] = 2; h[1] = 1;
        launch('{2, 5, 8, 11, 14, 17, 20, 23}, h, "ignore_start");
        repeat (30) @(posedge clk);
        #1;
        y_in = {N*YW{1'b1}}; h_in = {N*XW{1'b1}}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore_start");

        // Reset mid-run aborts immediately and suppresses done.
        h = hz; h[0] = -1; h[1] = 3;
        launch('{-5, 17, -6, 0, 0, 0, 0, 0}, h, "aborted");
        repeat (49) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_zero("midrun_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        h = hz; h[0] = 1;
        launch('{3, -4, 5, 0, 127, -128, 1, 2}, h, "after_reset"); wait_done("after_reset");

        // Back-to-back: the second start is raised during the done cycle.
        h = hz; h[0] = 2; h[1] = 1;
        launch('{2, 5, 8, 11, 14, 17, 20, 23}, h, "b2b_first");
        for (int i = 0; i < 400 && done !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        h = hz; h[0] = 1;
        launch('{1, 2, 3, 4, 5, 6, 7, 8}, h, "b2b_second"); wait_done("b2b_second");

        // Random kernels: y built by convolving random x, sometimes perturbed.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                xr[i] = int'($urandom_range(0, 255)) - 128;
                h[i]  = int'($urandom_range(0, 255)) - 128;
            end
            if (t == 5) h[0] = 0;
            else if (h[0] == 0) h[0] = 1;
            for (int n = 0; n < N; n++) begin
                y[n] = 0;
                for (int k = 0; k <= n; k++) y[n] += h[k] * xr[n-k];
                if ((t % 3) == 1) y[n] += int'($urandom_range(0, 6)) - 3;
            end
            launch(y, h, $sformatf("random%0d", t));
            wait_done($sformatf("random%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
